// File: rtl/usbdev_aon_wake_seq.sv
// AON wake sequencer: turns synchronized software suspend/ack pulses into the
// level handshake used by the USB AON wake detector, captures the wake cause
// into sticky status and reports wake / arm-failure events as single pulses.
module usbdev_aon_wake_seq #(
    parameter int unsigned SettleCycles = 4,
    parameter int unsigned ArmTimeout   = 16
) (
    input  logic       clk_aon_i,
    input  logic       rst_aon_ni,
    input  logic       suspend_req_i,
    input  logic       wake_ack_i,
    input  logic       wake_detect_active_i,
    input  logic       wake_req_i,
    input  logic       bus_not_idle_i,
    input  logic       bus_reset_i,
    input  logic       sense_lost_i,
    output logic       suspend_req_aon_o,
    output logic       wake_ack_aon_o,
    output logic       wake_evt_o,
    output logic       arm_err_o,
    output logic [2:0] cause_o,
    output logic [2:0] state_o,
    output logic       busy_o
);

    localparam logic [7:0] SettleLoad = 8'(SettleCycles - 1);
    localparam logic [7:0] ArmLoad    = 8'(ArmTimeout - 1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StSettle  = 3'd1,
        StArm     = 3'd2,
        StMonitor = 3'd3,
        StWake    = 3'd4,
        StRelease = 3'd5
    } state_e;

    state_e     state;
    logic [7:0] count;
    logic       ack_pending;
    logic [2:0] flags;

    assign flags   = {sense_lost_i, bus_reset_i, bus_not_idle_i};
    assign state_o = state;

    // Sequencer state, down-counter and all registered outputs.
    always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
        if (!rst_aon_ni) begin
            state             <= StIdle;
            count             <= '0;
            ack_pending       <= 1'b0;
            cause_o           <= '0;
            suspend_req_aon_o <= 1'b0;
            wake_ack_aon_o    <= 1'b0;
            wake_evt_o        <= 1'b0;
            arm_err_o         <= 1'b0;
            busy_o            <= 1'b0;
        end else begin
            wake_evt_o <= 1'b0;
            arm_err_o  <= 1'b0;
            case (state)
                StIdle: begin
                    if (suspend_req_i) begin
                        state   <= StSettle;
                        count   <= SettleLoad;
                        cause_o <= '0;
                        busy_o  <= 1'b1;
                    end
                end
                StSettle: begin
                    if (wake_ack_i) begin
                        state  <= StIdle;
                        busy_o <= 1'b0;
                    end else if (count == '0) begin
                        state             <= StArm;
                        count             <= ArmLoad;
                        suspend_req_aon_o <= 1'b1;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                StArm: begin
                    if (wake_ack_i) begin
                        state             <= StRelease;
                        suspend_req_aon_o <= 1'b0;
                        wake_ack_aon_o    <= 1'b1;
                    end else if (wake_detect_active_i) begin
                        state <= StMonitor;
                    end else if (count == '0) begin
                        state             <= StIdle;
                        arm_err_o         <= 1'b1;
                        suspend_req_aon_o <= 1'b0;
                        busy_o            <= 1'b0;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                StMonitor: begin
                    // A simultaneous ack is remembered so Wake hands over to
                    // Release after its single event cycle.
                    if (wake_req_i) begin
                        state             <= StWake;
                        cause_o           <= cause_o | flags;
                        ack_pending       <= wake_ack_i;
                        wake_evt_o        <= 1'b1;
                        suspend_req_aon_o <= 1'b0;
                    end else if (wake_ack_i) begin
                        state             <= StRelease;
                        suspend_req_aon_o <= 1'b0;
                        wake_ack_aon_o    <= 1'b1;
                    end else if (!wake_detect_active_i) begin
                        state             <= StIdle;
                        arm_err_o         <= 1'b1;
                        suspend_req_aon_o <= 1'b0;
                        busy_o            <= 1'b0;
                    end
                end
                StWake: begin
                    cause_o <= cause_o | flags;
                    if (wake_ack_i || ack_pending) begin
                        state          <= StRelease;
                        ack_pending    <= 1'b0;
                        wake_ack_aon_o <= 1'b1;
                    end
                end
                StRelease: begin
                    if (!wake_detect_active_i) begin
                        state          <= StIdle;
                        wake_ack_aon_o <= 1'b0;
                        busy_o         <= 1'b0;
                    end
                end
                default: begin
                    state             <= StIdle;
                    ack_pending       <= 1'b0;
                    suspend_req_aon_o <= 1'b0;
                    wake_ack_aon_o    <= 1'b0;
                    busy_o            <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usbdev_aon_wake_seq.sv
// Bench for usbdev_aon_wake_seq: directed scenarios followed by random
// stimulus, every cycle compared against a phase/elapsed-time reference model.
module tb_usbdev_aon_wake_seq;

    localparam int SETTLE = 4;
    localparam int ARMTO  = 16;

    localparam int P_IDLE = 0, P_SETTLE = 1, P_ARM = 2, P_MON = 3, P_WAKE = 4, P_REL = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       susp = 1'b0, ack = 1'b0, act = 1'b0, wreq = 1'b0;
    logic       nidle = 1'b0, brst = 1'b0, slost = 1'b0;
    logic       supp_o, wack_o, evt_o, err_o, busy_o;
    logic [2:0] cause_o, state_o;

    int checks = 0;
    int failures = 0;

    // model: current phase, cycles spent in it, sticky cause, pending ack, pulses
    int         m_phase = P_IDLE;
    int         m_elapsed = 0;
    logic [2:0] m_cause = '0;
    bit         m_ackp = 0;
    bit         m_evt = 0;
    bit         m_err = 0;

    always #5 clk = ~clk;

    usbdev_aon_wake_seq #(.SettleCycles(SETTLE), .ArmTimeout(ARMTO)) dut (
        .clk_aon_i           (clk),
        .rst_aon_ni          (rst_n),
        .suspend_req_i       (susp),
        .wake_ack_i          (ack),
        .wake_detect_active_i(act),
        .wake_req_i          (wreq),
        .bus_not_idle_i      (nidle),
        .bus_reset_i         (brst),
        .sense_lost_i        (slost),
        .suspend_req_aon_o   (supp_o),
        .wake_ack_aon_o      (wack_o),
        .wake_evt_o          (evt_o),
        .arm_err_o           (err_o),
        .cause_o             (cause_o),
        .state_o             (state_o),
        .busy_o              (busy_o)
    );

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_elapsed = 0; m_cause = '0; m_ackp = 0; m_evt = 0; m_err = 0;
    endtask

    // One rising edge of the reference behaviour, using the sampled inputs.
    task automatic model_step();
        int nxt;
        nxt = m_phase;
        m_evt = 0;
        m_err = 0;
        case (m_phase)
            P_IDLE: if (susp) begin nxt = P_SETTLE; m_cause = '0; end
            P_SETTLE: begin
                if (ack) nxt = P_IDLE;
                else if (m_elapsed == SETTLE - 1) nxt = P_ARM;
            end
            P_ARM: begin
                if (ack) nxt = P_REL;
                else if (act) nxt = P_MON;
                else if (m_elapsed == ARMTO - 1) begin nxt = P_IDLE; m_err = 1; end
            end
            P_MON: begin
                if (wreq) begin
                    nxt = P_WAKE; m_evt = 1; m_ackp = ack;
                    m_cause = m_cause | {slost, brst, nidle};
                end else if (ack) nxt = P_REL;
                else if (!act) begin nxt = P_IDLE; m_err = 1; end
            end
            P_WAKE: begin
                m_cause = m_cause | {slost, brst, nidle};
                if (ack || m_ackp) begin nxt = P_REL; m_ackp = 0; end
            end
            P_REL: if (!act) nxt = P_IDLE;
            default: nxt = P_IDLE;
        endcase
        m_elapsed = (nxt == m_phase) ? m_elapsed + 1 : 0;
        m_phase = nxt;
    endtask

    task automatic check_all();
        check_val("state", 8'(state_o), 8'(m_phase));
        check_val("suspend_req_aon", 8'(supp_o), 8'(m_phase == P_ARM || m_phase == P_MON));
        check_val("wake_ack_aon", 8'(wack_o), 8'(m_phase == P_REL));
        check_val("wake_evt", 8'(evt_o), 8'(m_evt));
        check_val("arm_err", 8'(err_o), 8'(m_err));
        check_val("cause", 8'(cause_o), 8'(m_cause));
        check_val("busy", 8'(busy_o), 8'(m_phase != P_IDLE));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare after it.
    task automatic cyc(input bit s, input bit a, input bit ac, input bit wr,
                       input bit ni, input bit br, input bit sl);
        @(negedge clk);
        susp = s; ack = a; act = ac; wreq = wr; nidle = ni; brst = br; slost = sl;
        @(posedge clk);
        model_step();
        #1 check_all();
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        susp = 0; ack = 0; wreq = 0;
        rst_n = 1'b1;
    endtask

    task automatic go_monitor();
        cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (SETTLE) cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check_val("reach_monitor", 8'(state_o), 8'd3);
    endtask

    initial begin
        bit r_act;
        #12;
        model_reset();
        check_all();
        check_val("reset_cause", 8'(cause_o), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: settle length, arm, detector rises two cycles later
        cyc(1, 0, 0, 0, 0, 0, 0);
        check_val("t1_settle", 8'(state_o), 8'd1);
        repeat (SETTLE - 1) cyc(0, 0, 0, 0, 0, 0, 0);
        check_val("t1_supp_low", 8'(supp_o), 8'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check_val("t1_supp_high", 8'(supp_o), 8'd1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check_val("t1_monitor", 8'(state_o), 8'd3);

        // 2: wake on bus reset, then software ack and detector release
        cyc(0, 0, 1, 1, 0, 1, 0);
        check_val("t2_evt", 8'(evt_o), 8'd1);
        check_val("t2_cause", 8'(cause_o), 8'b010);
        cyc(0, 0, 1, 1, 0, 0, 0);
        check_val("t2_evt_once", 8'(evt_o), 8'd0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        check_val("t2_wack", 8'(wack_o), 8'd1);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check_val("t2_idle", 8'(state_o), 8'd0);

        // 3: arm timeout
        cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (SETTLE) cyc(0, 0, 0, 0, 0, 0, 0);
        repeat (ARMTO - 1) cyc(0, 0, 0, 0, 0, 0, 0);
        check_val("t3_no_err_yet", 8'(err_o), 8'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check_val("t3_err", 8'(err_o), 8'd1);
        check_val("t3_idle", 8'(state_o), 8'd0);
        check_val("t3_supp", 8'(supp_o), 8'd0);

        // 4: simultaneous wake request and ack
        go_monitor();
        cyc(0, 1, 1, 1, 0, 0, 1);
        check_val("t4_wake", 8'(state_o), 8'd4);
        check_val("t4_evt", 8'(evt_o), 8'd1);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check_val("t4_release", 8'(state_o), 8'd5);
        check_val("t4_cause", 8'(cause_o), 8'b100);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // 5: software resume, suspend during Release ignored
        go_monitor();
        cyc(0, 1, 1, 0, 0, 0, 0);
        check_val("t5_release", 8'(state_o), 8'd5);
        check_val("t5_no_evt", 8'(evt_o), 8'd0);
        check_val("t5_cause", 8'(cause_o), 8'd0);
        cyc(1, 0, 1, 0, 0, 0, 0);
        check_val("t5_ignored", 8'(state_o), 8'd5);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // 6: reset during Wake
        go_monitor();
        cyc(0, 0, 1, 1, 1, 1, 1);
        check_val("t6_wake", 8'(state_o), 8'd4);
        async_reset();
        check_val("t6_state", 8'(state_o), 8'd0);
        check_val("t6_cause", 8'(cause_o), 8'd0);

        // random phase with a loosely behaving detector
        r_act = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(399) == 0) begin
                async_reset();
                r_act = 0;
            end
            if (m_phase == P_ARM && !r_act && $urandom_range(2) == 0) r_act = 1;
            else if (m_phase == P_REL && r_act && $urandom_range(2) == 0) r_act = 0;
            else if (r_act && $urandom_range(15) == 0) r_act = 0;
            else if (!r_act && $urandom_range(31) == 0) r_act = 1;
            cyc($urandom_range(3) == 0, $urandom_range(9) == 0, r_act,
                $urandom_range(5) == 0, 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
